// File: rtl/game_pkg.sv
// Shared types, widths and helpers for the reaction-time game sequencer.
package game_pkg;

  localparam int unsigned MS_W = 14;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ARM, ST_WAIT, ST_GO, ST_SHOW, ST_FOUL, ST_DONE
  } state_e;

  typedef enum logic [2:0] {
    HEX_OFF   = 3'd0,
    HEX_READY = 3'd1,
    HEX_WAIT  = 3'd2,
    HEX_GO    = 3'd3,
    HEX_TIME  = 3'd4,
    HEX_FOUL  = 3'd5,
    HEX_DONE  = 3'd6
  } hex_instr_e;

  // Start delay in ms for a given LFSR code.
  function automatic logic [MS_W-1:0] start_delay(input logic [3:0] code,
                                                  input int unsigned min_ms,
                                                  input int unsigned step_ms);
    return MS_W'(min_ms + 32'(code) * step_ms);
  endfunction

endpackage

// File: rtl/reaction_round_ctrl_if.sv
// Game-side signal bundle: tick/key/switch/LFSR inputs and display/score outputs.
interface reaction_round_ctrl_if;

  logic                     tick_1ms;
  logic                     enable;
  logic                     key_n;
  logic [3:0]               rand_code;
  logic                     rand_req;
  logic [2:0]               hex_instr;
  logic                     led_go;
  logic [3:0]               round_idx;
  logic [game_pkg::MS_W-1:0] last_ms;
  logic [game_pkg::MS_W-1:0] best_ms;
  logic                     foul;
  logic                     done;

  modport master (
    output tick_1ms, enable, key_n, rand_code,
    input  rand_req, hex_instr, led_go, round_idx, last_ms, best_ms, foul, done
  );

  modport slave (
    input  tick_1ms, enable, key_n, rand_code,
    output rand_req, hex_instr, led_go, round_idx, last_ms, best_ms, foul, done
  );

endinterface

// File: rtl/key_sync_edge.sv
// Two-stage synchronizer for an active-low pushbutton plus a falling-edge pulse.
module key_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  // sync[1:0] are the metastability stages, sync[2] holds the previous level.
  logic [2:0] sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '1;
    else        sync <= {sync[1:0], key_n};
  end

  assign press = sync[2] & ~sync[1];

endmodule

// File: rtl/reaction_round_ctrl.sv
// Round sequencer for the reaction-time game: random delay, reaction timing,
// false-start detection, round counting and best/last score tracking.
module reaction_round_ctrl
  import game_pkg::*;
#(
  parameter int unsigned ROUNDS        = 3,
  parameter int unsigned MIN_DELAY_MS  = 1000,
  parameter int unsigned DELAY_STEP_MS = 250,
  parameter int unsigned HOLD_MS       = 2000,
  parameter int unsigned MAX_MS        = 9999
) (
  input  logic                 clk,
  input  logic                 rst_n,
  reaction_round_ctrl_if.slave bus
);

  localparam logic [MS_W-1:0] ONE        = MS_W'(1);
  localparam logic [MS_W-1:0] MAX_CNT    = MS_W'(MAX_MS);
  localparam logic [MS_W-1:0] HOLD_CNT   = MS_W'(HOLD_MS);
  localparam logic [3:0]      LAST_ROUND = 4'(ROUNDS - 1);

  state_e          state;
  hex_instr_e      hex_instr;
  logic [MS_W-1:0] cnt;
  logic [MS_W-1:0] last_ms;
  logic [MS_W-1:0] best_ms;
  logic [3:0]      round_idx;
  logic            rand_req;
  logic            led_go;
  logic            foul;
  logic            done;
  logic            press;

  key_sync_edge u_key (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (bus.key_n),
    .press (press)
  );

  // cnt is shared: delay countdown in WAIT, reaction count-up in GO,
  // hold countdown in SHOW/FOUL. Press is tested before tick everywhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      hex_instr <= HEX_OFF;
      cnt       <= '0;
      last_ms   <= '0;
      best_ms   <= MAX_CNT;
      round_idx <= '0;
      rand_req  <= 1'b0;
      led_go    <= 1'b0;
      foul      <= 1'b0;
      done      <= 1'b0;
    end else begin
      rand_req <= 1'b0;
      foul     <= 1'b0;
      if (!bus.enable) begin
        state     <= ST_IDLE;
        hex_instr <= HEX_READY;
        round_idx <= '0;
        led_go    <= 1'b0;
        done      <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            hex_instr <= HEX_READY;
            if (press) begin
              state     <= ST_ARM;
              hex_instr <= HEX_WAIT;
              rand_req  <= 1'b1;
            end
          end
          ST_ARM: begin
            cnt   <= start_delay(bus.rand_code, MIN_DELAY_MS, DELAY_STEP_MS);
            state <= ST_WAIT;
          end
          ST_WAIT: begin
            if (press) begin
              state     <= ST_FOUL;
              hex_instr <= HEX_FOUL;
              foul      <= 1'b1;
              cnt       <= HOLD_CNT;
            end else if (bus.tick_1ms) begin
              if (cnt <= ONE) begin
                state     <= ST_GO;
                hex_instr <= HEX_GO;
                led_go    <= 1'b1;
                cnt       <= '0;
              end else begin
                cnt <= cnt - ONE;
              end
            end
          end
          ST_GO: begin
            if (press || cnt == MAX_CNT) begin
              state     <= ST_SHOW;
              hex_instr <= HEX_TIME;
              led_go    <= 1'b0;
              last_ms   <= cnt;
              cnt       <= HOLD_CNT;
              if (press && cnt < best_ms) best_ms <= cnt;
            end else if (bus.tick_1ms) begin
              cnt <= cnt + ONE;
            end
          end
          ST_SHOW, ST_FOUL: begin
            if (bus.tick_1ms) begin
              if (cnt > ONE) begin
                cnt <= cnt - ONE;
              end else if (state == ST_SHOW && round_idx == LAST_ROUND) begin
                state     <= ST_DONE;
                hex_instr <= HEX_DONE;
                done      <= 1'b1;
              end else begin
                if (state == ST_SHOW) round_idx <= round_idx + 4'd1;
                state     <= ST_ARM;
                hex_instr <= HEX_WAIT;
                rand_req  <= 1'b1;
              end
            end
          end
          ST_DONE: begin
            if (press) begin
              state     <= ST_ARM;
              hex_instr <= HEX_WAIT;
              done      <= 1'b0;
              round_idx <= '0;
              rand_req  <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.rand_req  = rand_req;
  assign bus.hex_instr = hex_instr;
  assign bus.led_go    = led_go;
  assign bus.round_idx = round_idx;
  assign bus.last_ms   = last_ms;
  assign bus.best_ms   = best_ms;
  assign bus.foul      = foul;
  assign bus.done      = done;

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// Scoreboard bench for reaction_round_ctrl: expected display events are queued
// by the stimulus and checked by a monitor on every hex_instr change or reset.
module tb_reaction_round_ctrl;
  import game_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic stim_done = 1'b0;

  reaction_round_ctrl_if bus ();

  reaction_round_ctrl #(
    .ROUNDS        (3),
    .MIN_DELAY_MS  (1000),
    .DELAY_STEP_MS (250),
    .HOLD_MS       (2000),
    .MAX_MS        (9999)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  hex;
    logic [3:0]  rnd;
    logic [13:0] last;
    logic [13:0] best;
    logic        go;
    logic        dn;
    int unsigned nf;
    int unsigned nr;
  } exp_t;

  exp_t sb[$];

  task automatic expect_ev(input string name, input hex_instr_e hex,
                           input int unsigned rnd, input int unsigned last,
                           input int unsigned best, input int unsigned nf,
                           input int unsigned nr);
    exp_t e;
    e.name = name;
    e.hex  = hex;
    e.rnd  = 4'(rnd);
    e.last = 14'(last);
    e.best = 14'(best);
    e.go   = (hex == HEX_GO);
    e.dn   = (hex == HEX_DONE);
    e.nf   = nf;
    e.nr   = nr;
    sb.push_back(e);
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk); bus.tick_1ms = 1'b1;
      @(negedge clk); bus.tick_1ms = 1'b0;
    end
  endtask

  // The FSM acts on the third posedge after key_n falls; with_tick puts a
  // tick on exactly that edge.
  task automatic press_key(input bit with_tick);
    @(negedge clk); bus.key_n = 1'b0;
    @(negedge clk);
    @(negedge clk); if (with_tick) bus.tick_1ms = 1'b1;
    @(negedge clk); bus.tick_1ms = 1'b0; bus.key_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin : monitor
    int unsigned n_tests;
    int unsigned n_fail;
    int unsigned n_foul;
    int unsigned n_rand;
    logic [2:0]  prev_hex;
    logic        rst_last;
    logic        forced;
    exp_t        e;
    n_tests  = 0;
    n_fail   = 0;
    n_foul   = 0;
    n_rand   = 0;
    prev_hex = 3'h7;
    rst_last = 1'b1;
    forever begin
      @(negedge clk or negedge rst_n);
      forced   = rst_last && !rst_n;
      rst_last = rst_n;
      #1;
      if (bus.rand_req === 1'b1) n_rand++;
      if (bus.foul === 1'b1) n_foul++;
      if (forced || bus.hex_instr !== prev_hex) begin
        prev_hex = bus.hex_instr;
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: got hex=%0d round=%0d last=%0d best=%0d, required no event",
                   bus.hex_instr, bus.round_idx, bus.last_ms, bus.best_ms);
        end else begin
          e = sb.pop_front();
          if (bus.hex_instr !== e.hex || bus.round_idx !== e.rnd ||
              bus.last_ms !== e.last || bus.best_ms !== e.best ||
              bus.led_go !== e.go || bus.done !== e.dn ||
              n_foul != e.nf || n_rand != e.nr) begin
            n_fail++;
            $display("FAIL %s: got hex=%0d round=%0d last=%0d best=%0d go=%0b done=%0b fouls=%0d reqs=%0d; required hex=%0d round=%0d last=%0d best=%0d go=%0b done=%0b fouls=%0d reqs=%0d",
                     e.name, bus.hex_instr, bus.round_idx, bus.last_ms, bus.best_ms,
                     bus.led_go, bus.done, n_foul, n_rand,
                     e.hex, e.rnd, e.last, e.best, e.go, e.dn, e.nf, e.nr);
          end
        end
      end
      if (stim_done) begin
        n_tests++;
        if (sb.size() != 0) begin
          n_fail++;
          $display("FAIL scoreboard_drain: got %0d pending events (next %s), required 0",
                   sb.size(), sb[0].name);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "time limit");
  end

  initial begin : stimulus
    bus.tick_1ms  = 1'b0;
    bus.enable    = 1'b1;
    bus.key_n     = 1'b1;
    bus.rand_code = 4'd0;

    expect_ev("reset_values", HEX_OFF, 0, 0, 9999, 0, 0);
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    expect_ev("idle_ready", HEX_READY, 0, 0, 9999, 0, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Game A: reactions 300, 180, 250 with 1000 ms delays.
    expect_ev("a0_arm",  HEX_WAIT, 0, 0, 9999, 0, 1);   press_key(0);
    expect_ev("a0_go",   HEX_GO,   0, 0, 9999, 0, 1);   ticks(1000);
    expect_ev("a0_show", HEX_TIME, 0, 300, 300, 0, 1);  ticks(300); press_key(0);
    expect_ev("a1_arm",  HEX_WAIT, 1, 300, 300, 0, 2);  ticks(2000);
    expect_ev("a1_go",   HEX_GO,   1, 300, 300, 0, 2);  ticks(1000);
    expect_ev("a1_show", HEX_TIME, 1, 180, 180, 0, 2);  ticks(180); press_key(0);
    expect_ev("a2_arm",  HEX_WAIT, 2, 180, 180, 0, 3);  ticks(2000);
    expect_ev("a2_go",   HEX_GO,   2, 180, 180, 0, 3);  ticks(1000);
    expect_ev("a2_show", HEX_TIME, 2, 250, 180, 0, 3);  ticks(250); press_key(0);
    expect_ev("a_done",  HEX_DONE, 2, 250, 180, 0, 3);  ticks(2000);

    // Restart from DONE, then asynchronous reset in the middle of WAIT.
    expect_ev("b_arm", HEX_WAIT, 0, 250, 180, 0, 4);    press_key(0);
    ticks(300);
    expect_ev("b_async_reset", HEX_OFF, 0, 0, 9999, 0, 4);
    @(negedge clk); #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    expect_ev("b_ready", HEX_READY, 0, 0, 9999, 0, 4);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Game C: rand_code 4 gives a 2000 ms delay for the first round only.
    bus.rand_code = 4'd4;
    expect_ev("c0_arm",  HEX_WAIT, 0, 0, 9999, 0, 5);   press_key(0);
    bus.rand_code = 4'd0;
    expect_ev("c0_go",   HEX_GO,   0, 0, 9999, 0, 5);   ticks(2000);
    expect_ev("c0_show", HEX_TIME, 0, 237, 237, 0, 5);  ticks(237); press_key(0);
    expect_ev("c1_arm",  HEX_WAIT, 1, 237, 237, 0, 6);  ticks(2000);
    expect_ev("c1_foul_early", HEX_FOUL, 1, 237, 237, 1, 6); ticks(500); press_key(0);
    expect_ev("c1_rearm", HEX_WAIT, 1, 237, 237, 1, 7); ticks(2000);
    expect_ev("c1_foul_final_tick", HEX_FOUL, 1, 237, 237, 2, 7); ticks(999); press_key(1);
    expect_ev("c1_rearm2", HEX_WAIT, 1, 237, 237, 2, 8); ticks(2000);
    expect_ev("c1_go",   HEX_GO,   1, 237, 237, 2, 8);  ticks(1000);
    expect_ev("c1_show_press_on_tick", HEX_TIME, 1, 99, 99, 2, 8); ticks(99); press_key(1);
    expect_ev("c2_arm",  HEX_WAIT, 2, 99, 99, 2, 9);    ticks(2000);
    expect_ev("c2_go",   HEX_GO,   2, 99, 99, 2, 9);    ticks(1000);
    ticks(20);
    expect_ev("c2_enable_abort", HEX_READY, 0, 99, 99, 2, 9);
    @(negedge clk); bus.enable = 1'b0;
    repeat (4) @(negedge clk);
    bus.enable = 1'b1;
    @(negedge clk);

    // Timeout: no press in GO.
    expect_ev("d0_arm",     HEX_WAIT, 0, 99, 99, 2, 10); press_key(0);
    expect_ev("d0_go",      HEX_GO,   0, 99, 99, 2, 10); ticks(1000);
    expect_ev("d0_timeout", HEX_TIME, 0, 9999, 99, 2, 10); ticks(9999);
    repeat (5) @(negedge clk);
    stim_done = 1'b1;
  end

endmodule

// File: doc/reaction_round_ctrl.md
# reaction_round_ctrl

Sequencer for the reaction-time mini-game. It draws a random start delay from the LFSR, counts the delay and the player's reaction in 1 ms ticks, and detects false starts. It runs a fixed number of rounds, tracks the last and best reaction times, and drives the 3-bit instruction code consumed by the HEX display controller. It sits between the 1 kHz tick, the LFSR, the pushbutton/switch inputs and the display path, and replaces the ad-hoc delay/FSM coupling at the top level.

## Interface
Parameters:
- ROUNDS, 3: rounds per game (1–15).
- MIN_DELAY_MS, 1000: delay for rand_code = 0.
- DELAY_STEP_MS, 250: added delay per rand_code LSB.
- HOLD_MS, 2000: result/foul display time.
- MAX_MS, 9999: reaction saturation value, also the timeout.

Ports:
- clk, in, 1: system clock (50 MHz).
- rst_n, in, 1: asynchronous active-low reset.
- tick_1ms, in, 1: one-clk pulse every 1 ms, synchronous to clk.
- enable, in, 1: game enable switch, level.
- key_n, in, 1: raw pushbutton, active-low, asynchronous.
- rand_code, in, 4: current LFSR value.
- rand_req, out, 1: one-clk pulse asking the LFSR to advance.
- hex_instr, out, 3: display code (see Structure).
- led_go, out, 1: high while in GO.
- round_idx, out, 4: current round, 0-based.
- last_ms, out, 14: last valid reaction time.
- best_ms, out, 14: minimum valid reaction time.
- foul, out, 1: one-clk pulse when a false start occurs.
- done, out, 1: high in DONE.

## Operation
- key_n passes through a 2-FF synchronizer. `press` is a one-clk pulse on the synchronized falling edge.
- States:
  - IDLE → ARM on press while enable=1.
  - ARM (1 clk): rand_req=1; load delay_cnt = MIN_DELAY_MS + rand_code*DELAY_STEP_MS; go to WAIT.
  - WAIT: decrement delay_cnt on each tick. press → FOUL. delay_cnt reaching 0 → GO with react_cnt=0.
  - GO: increment react_cnt on each tick, saturating at MAX_MS.
    - press → SHOW with last_ms=react_cnt; best_ms=min(best_ms, react_cnt).
    - react_cnt = MAX_MS → SHOW with last_ms=MAX_MS; best_ms is not updated.
  - SHOW: hold HOLD_MS ticks. Then, if round_idx = ROUNDS-1, go to DONE; otherwise increment round_idx and go to ARM.
  - FOUL: foul pulses on entry. Hold HOLD_MS ticks, then return to ARM with the same round_idx.
  - DONE: press → ARM with round_idx=0.
- enable=0 in any state forces IDLE on the next clk and clears round_idx. last_ms and best_ms are kept.
- Simultaneous events:
  - press has priority over a tick in the same clk.
  - In WAIT, a press in the same clk as the final tick is a FOUL.
  - In GO, a press in the same clk as a tick latches react_cnt before the increment.
- Widths: all ms counters are 14 bits. Maximum delay is 1000 + 15*250 = 4750.

## Timing
- Reset values:
  - State = IDLE.
  - rand_req=0, led_go=0, foul=0, done=0, round_idx=0.
  - last_ms=0, best_ms=MAX_MS, hex_instr=OFF.
- All outputs are registered.
- Key-to-state latency is 3 clk: 2 synchronizer stages plus 1 edge register.
- Pressing KEY[0] is a high→low transition on key_n.
- rand_code is sampled in the ARM clk. The LFSR advances after that clk.
- The delay resolution is ±1 tick, because the first tick can arrive anywhere up to 1 ms after entering WAIT.
- Reset mid-game returns to the reset values immediately (asynchronous).

## Structure
- Package game_pkg:
  - state enum: IDLE, ARM, WAIT, GO, SHOW, FOUL, DONE.
  - hex_instr_e codes: OFF=0, READY=1, WAIT=2, GO=3, TIME=4, FOUL=5, DONE=6.
  - MS_W=14.
- hex_instr mapping by state:
  - IDLE → READY.
  - ARM/WAIT → WAIT.
  - GO → GO.
  - SHOW → TIME.
  - FOUL → FOUL.
  - DONE → DONE.
- Sub-module key_sync_edge: 2-FF synchronizer plus falling-edge pulse, reused for the other KEYs.

## Test plan
- Normal round: enable=1, press, rand_code=4 → rand_req pulses once; GO after 2000 ticks; press after 237 ticks → last_ms=237, best_ms=237, hex_instr=TIME.
- Best tracking, with ROUNDS=3: reactions 300, 180, 250 → best_ms=180, last_ms=250, done=1 after the third SHOW hold, round_idx=2.
- False start: press at tick 500 of WAIT → foul pulse, hex_instr=FOUL for 2000 ticks, back to ARM with round_idx unchanged; best_ms unchanged.
- Simultaneous events:
  - Press in the same clk as the final WAIT tick → FOUL.
  - Press in the same clk as a GO tick with react_cnt=99 → last_ms=99.
- Timeout: no press in GO → last_ms=9999 after 9999 ticks, best_ms unchanged, SHOW entered.
- Abort and reset:
  - enable dropped in GO → IDLE next clk, round_idx=0, last_ms/best_ms kept.
  - rst_n low mid-WAIT → all outputs at reset values asynchronously.
